// File: rtl/note_display_scheduler.sv
// Note display scheduler: buffers note events from the key logic and sequences them onto the
// two-digit letter/octave seven-segment display. Each note gets a minimum hold time, and the
// display blanks after an idle timeout.
// Optional feature macro: SHARP_DP_EN adds an active-low decimal point output that is lit for
// sharps.
module note_display_scheduler #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned IDLE_CYCLES = 200_000_000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       note_valid,
    output logic       note_ready,
    input  logic [3:0] note_semi,
    input  logic [3:0] note_oct,
    output logic [6:0] letter_seg,
    output logic [6:0] number_seg,
    output logic       busy,
    output logic       err_invalid
`ifdef SHARP_DP_EN
    ,
    output logic       sharp_dp
`endif
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES);
    localparam int unsigned IdleW = $clog2(IDLE_CYCLES);

    localparam logic [CntW-1:0]  Full     = CntW'(FIFO_DEPTH);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_CYCLES - 1);
    localparam logic [6:0]       Blank    = 7'h7F;

    typedef enum logic [1:0] {StIdle, StShow, StLinger} state_e;

    // Segment patterns are {g,f,e,d,c,b,a}, active-low; sharps reuse the natural below them.
    function automatic logic [6:0] letter_of(input logic [3:0] semi);
        logic [6:0] seg;
        case (semi)
            4'd0, 4'd1:  seg = 7'b1000110; // C
            4'd2, 4'd3:  seg = 7'b0100001; // d
            4'd4:        seg = 7'b0000110; // E
            4'd5, 4'd6:  seg = 7'b0001110; // F
            4'd7, 4'd8:  seg = 7'b1000010; // G
            4'd9, 4'd10: seg = 7'b0001000; // A
            4'd11:       seg = 7'b0000011; // b
            default:     seg = Blank;
        endcase
        return seg;
    endfunction

    function automatic logic [6:0] digit_of(input logic [3:0] oct);
        logic [6:0] seg;
        case (oct)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            default: seg = Blank;
        endcase
        return seg;
    endfunction

`ifdef SHARP_DP_EN
    function automatic logic is_sharp(input logic [3:0] semi);
        return (semi == 4'd1) || (semi == 4'd3) || (semi == 4'd6) ||
               (semi == 4'd8) || (semi == 4'd10);
    endfunction
`endif

    state_e            state_q, state_d;
    logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;
    logic [6:0]        letter_q, letter_d;
    logic [6:0]        number_q, number_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
`ifdef SHARP_DP_EN
    logic              sharp_q, sharp_d;
`endif

    logic       accept;
    logic       evt_ok;
    logic       push;
    logic       pop;
    logic       load;
    logic       empty;
    logic [3:0] head_semi;
    logic [3:0] head_oct;

    // Input handshake and FIFO bookkeeping; invalid events are consumed but never stored.
    always_comb begin
        accept    = note_valid & ready_q;
        evt_ok    = (note_semi < 4'd12) && (note_oct < 4'd9);
        push      = accept & evt_ok;
        err_d     = accept & ~evt_ok;
        empty     = (cnt_q == '0);
        head_semi = mem_q[rd_ptr_q][7:4];
        head_oct  = mem_q[rd_ptr_q][3:0];
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // Ready follows the registered count, so it stays low for a whole full cycle.
        ready_d = (cnt_d != Full);
    end

    // Display FSM: IDLE -> SHOW (fixed hold) -> LINGER (until next note or idle timeout).
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        idle_cnt_d = idle_cnt_q;
        letter_d   = letter_q;
        number_d   = number_q;
        pop        = 1'b0;
        load       = 1'b0;
`ifdef SHARP_DP_EN
        sharp_d    = sharp_q;
`endif
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    load = 1'b1;
                end
            end
            StShow: begin
                if (hold_cnt_q == HoldLast) begin
                    idle_cnt_d = '0;
                    state_d    = StLinger;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StLinger: begin
                // A waiting note wins over the timeout in the same cycle.
                if (!empty) begin
                    load = 1'b1;
                end else if (idle_cnt_q == IdleLast) begin
                    letter_d = Blank;
                    number_d = Blank;
`ifdef SHARP_DP_EN
                    sharp_d  = 1'b1;
`endif
                    state_d  = StIdle;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (load) begin
            pop        = 1'b1;
            letter_d   = letter_of(head_semi);
            number_d   = digit_of(head_oct);
`ifdef SHARP_DP_EN
            sharp_d    = ~is_sharp(head_semi);
`endif
            hold_cnt_d = '0;
            state_d    = StShow;
        end
        busy_d = (state_d != StIdle);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            idle_cnt_q <= '0;
            letter_q   <= Blank;
            number_q   <= Blank;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
`ifdef SHARP_DP_EN
            sharp_q    <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            letter_q   <= letter_d;
            number_q   <= number_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
`ifdef SHARP_DP_EN
            sharp_q    <= sharp_d;
`endif
        end
    end

    // FIFO storage; contents need no reset since the count gates every read.
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            mem_q[wr_ptr_q] <= {note_semi, note_oct};
        end
    end

    assign note_ready  = ready_q;
    assign letter_seg  = letter_q;
    assign number_seg  = number_q;
    assign busy        = busy_q;
    assign err_invalid = err_q;
`ifdef SHARP_DP_EN
    assign sharp_dp    = sharp_q;
`endif

endmodule
